// File: rtl/jesd_tx_seq.sv
// JESD204 transmit link sequencer: CGS, ILAS and DATA character generation
// for an 8b/10b encoder, locked to a free-running LMFC position counter.
module jesd_tx_seq #(
  parameter int F = 2,
  parameter int K = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_sync_n,
  input  logic [7:0]   i_data,
  input  logic [111:0] i_cfg,
  output logic         o_data_req,
  output logic [7:0]   o_addr,
  output logic         o_k,
  output logic         o_rd_en,
  output logic [1:0]   o_state
);

  typedef enum logic [1:0] {
    CGS  = 2'd0,
    ILAS = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam int         FK      = F * K;
  localparam logic [7:0] PosLast = 8'(FK - 1);
  localparam logic [3:0] FrmLast = 4'(F - 1);

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_7 = 8'hFC;

  state_e      state_q, state_d;
  logic [7:0]  pos_q;
  logic [3:0]  fpos_q;
  logic [1:0]  mf_q;
  logic [7:0]  prev_q;
  logic        prev_vld_q;
  logic [7:0]  addr_q;
  logic        k_q;
  logic        rd_en_q;

  logic        pos_last;
  logic        frm_last;
  logic        cfg_win;
  logic [3:0]  cfg_idx;
  logic [7:0]  cfg_oct [16];
  logic [7:0]  char_d;
  logic        k_d;

  for (genvar n = 0; n < 14; n++) begin : g_cfg
    assign cfg_oct[n] = i_cfg[8*n +: 8];
  end
  assign cfg_oct[14] = 8'h00;
  assign cfg_oct[15] = 8'h00;

  assign pos_last = (pos_q == PosLast);
  assign frm_last = (fpos_q == FrmLast);
  assign cfg_win  = (mf_q == 2'd1) && (pos_q >= 8'd2)
                    && (pos_q <= 8'd15);
  assign cfg_idx  = pos_q[3:0] - 4'd2;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CGS;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; loss of SYNC~ beats any progression
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CGS: begin
        if (i_sync_n && pos_last) state_d = ILAS;
      end
      ILAS: begin
        if (!i_sync_n) begin
          state_d = CGS;
        end else if (pos_last && (mf_q == 2'd3)) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (!i_sync_n) state_d = CGS;
      end
      default: state_d = CGS;
    endcase
  end

  // Character selection for the current cycle
  always_comb begin
    char_d = K28_5;
    k_d    = 1'b1;
    unique case (state_q)
      ILAS: begin
        unique case (1'b1)
          (pos_q == 8'd0): begin
            char_d = K28_0;
            k_d    = 1'b1;
          end
          pos_last: begin
            char_d = K28_3;
            k_d    = 1'b1;
          end
          ((mf_q == 2'd1) && (pos_q == 8'd1)): begin
            char_d = K28_4;
            k_d    = 1'b1;
          end
          cfg_win: begin
            char_d = cfg_oct[cfg_idx];
            k_d    = 1'b0;
          end
          default: begin
            char_d = pos_q;
            k_d    = 1'b0;
          end
        endcase
      end
      DATA: begin
        if (frm_last && prev_vld_q && (i_data == prev_q)) begin
          char_d = pos_last ? K28_3 : K28_7;
          k_d    = 1'b1;
        end else begin
          char_d = i_data;
          k_d    = 1'b0;
        end
      end
      default: begin
        char_d = K28_5;
        k_d    = 1'b1;
      end
    endcase
  end

  // LMFC position and multiframe counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= 8'd0;
      fpos_q <= 4'd0;
      mf_q   <= 2'd0;
    end else begin
      pos_q  <= pos_last ? 8'd0 : pos_q + 8'd1;
      fpos_q <= frm_last ? 4'd0 : fpos_q + 4'd1;
      if (state_q != ILAS && state_d == ILAS) begin
        mf_q <= 2'd0;
      end else if (state_q == ILAS && pos_last) begin
        mf_q <= mf_q + 2'd1;
      end
    end
  end

  // Raw last octet of the previous DATA frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= 8'h00;
      prev_vld_q <= 1'b0;
    end else if (state_q != DATA && state_d == DATA) begin
      prev_vld_q <= 1'b0;
    end else if (state_q == DATA && frm_last) begin
      prev_q     <= i_data;
      prev_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= K28_5;
      k_q     <= 1'b1;
      rd_en_q <= 1'b0;
    end else begin
      addr_q  <= char_d;
      k_q     <= k_d;
      rd_en_q <= 1'b1;
    end
  end

  assign o_data_req = (state_q == DATA);
  assign o_addr     = addr_q;
  assign o_k        = k_q;
  assign o_rd_en    = rd_en_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_jesd_tx_seq.sv
// Directed bench for jesd_tx_seq with F=2, K=16 (32 octets per multiframe).
module tb_jesd_tx_seq;

  logic         clk;
  logic         rst_n;
  logic         sync_n;
  logic [7:0]   data;
  logic [111:0] cfg;
  logic         data_req;
  logic [7:0]   addr;
  logic         k;
  logic         rd_en;
  logic [1:0]   state;

  int nerr = 0;
  int nchk = 0;
  int tpos = 0;

  jesd_tx_seq #(.F(2), .K(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sync_n   (sync_n),
    .i_data     (data),
    .i_cfg      (cfg),
    .o_data_req (data_req),
    .o_addr     (addr),
    .o_k        (k),
    .o_rd_en    (rd_en),
    .o_state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tpos = (tpos == 31) ? 0 : tpos + 1;
  endtask

  function automatic logic [8:0] ilas_exp(input int m, input int p);
    if (p == 0)                     return {1'b1, 8'h1C};
    if (p == 31)                    return {1'b1, 8'h7C};
    if (m == 1 && p == 1)           return {1'b1, 8'h9C};
    if (m == 1 && p >= 2 && p <= 15) return {1'b0, 8'(8'hA0 + p - 2)};
    return {1'b0, 8'(p)};
  endfunction

  task automatic chk_ilas(input int m, input int p);
    logic [8:0] e;
    e = ilas_exp(m, p);
    chk("ilas_state", 32'(state), 32'd1);
    step();
    chk("ilas_addr", 32'(addr), 32'(e[7:0]));
    chk("ilas_k", 32'(k), 32'(e[8]));
  endtask

  initial begin
    rst_n  = 1'b0;
    sync_n = 1'b0;
    data   = 8'h00;
    for (int n = 0; n < 14; n++) cfg[8*n +: 8] = 8'(8'hA0 + n);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 32'(addr), 32'hBC);
    chk("rst_k", 32'(k), 32'd1);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_req", 32'(data_req), 32'd0);
    #2;
    rst_n = 1'b1;
    tpos  = 0;

    // CGS hold with SYNC~ asserted
    for (int i = 0; i < 100; i++) begin
      step();
      chk("cgs_addr", 32'(addr), 32'hBC);
      chk("cgs_k", 32'(k), 32'd1);
      chk("cgs_rd_en", 32'(rd_en), 32'd1);
      chk("cgs_state", 32'(state), 32'd0);
    end

    while (tpos != 10) begin
      step();
      chk("cgs_wait", 32'(addr), 32'hBC);
    end
    sync_n = 1'b1;
    while (tpos != 31) begin
      step();
      chk("cgs_hold_state", 32'(state), 32'd0);
      chk("cgs_hold_addr", 32'(addr), 32'hBC);
    end
    step();
    chk("ilas_entry_state", 32'(state), 32'd1);
    chk("ilas_entry_addr", 32'(addr), 32'hBC);

    for (int m = 0; m < 4; m++)
      for (int p = 0; p < 32; p++) chk_ilas(m, p);
    chk("data_entry_state", 32'(state), 32'd2);

    // DATA with incrementing octets: never replaced
    for (int i = 0; i < 64; i++) begin
      data = 8'(i);
      chk("inc_req", 32'(data_req), 32'd1);
      step();
      chk("inc_addr", 32'(addr), 32'(i));
      chk("inc_k", 32'(k), 32'd0);
    end

    // DATA with constant 0x55: frame ends replaced after the first frame
    data = 8'h55;
    for (int i = 0; i < 64; i++) begin
      int p;
      p = tpos;
      step();
      if (p % 2 == 0 || i == 1) begin
        chk("const_addr", 32'(addr), 32'h55);
        chk("const_k", 32'(k), 32'd0);
      end else if (p == 31) begin
        chk("const_eomf", 32'(addr), 32'h7C);
        chk("const_eomf_k", 32'(k), 32'd1);
      end else begin
        chk("const_eof", 32'(addr), 32'hFC);
        chk("const_eof_k", 32'(k), 32'd1);
      end
    end

    // One-cycle SYNC~ drop mid-DATA
    while (tpos != 5) begin
      data = 8'(tpos);
      step();
    end
    data   = 8'hAA;
    sync_n = 1'b0;
    step();
    chk("drop_addr", 32'(addr), 32'hAA);
    chk("drop_state", 32'(state), 32'd0);
    chk("drop_req", 32'(data_req), 32'd0);
    sync_n = 1'b1;
    step();
    chk("drop_bc", 32'(addr), 32'hBC);
    chk("drop_bc_k", 32'(k), 32'd1);
    while (tpos != 31) begin
      chk("resync_state", 32'(state), 32'd0);
      step();
      chk("resync_addr", 32'(addr), 32'hBC);
    end
    chk("resync_pre", 32'(state), 32'd0);
    step();
    chk("resync_ilas", 32'(state), 32'd1);

    for (int m = 0; m < 2; m++)
      for (int p = 0; p < 32; p++) chk_ilas(m, p);
    for (int p = 0; p < 5; p++) chk_ilas(2, p);

    // Asynchronous reset in ILAS multiframe 2
    rst_n = 1'b0;
    #1;
    chk("abort_addr", 32'(addr), 32'hBC);
    chk("abort_k", 32'(k), 32'd1);
    chk("abort_rd_en", 32'(rd_en), 32'd0);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_req", 32'(data_req), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tpos  = 0;
    step();
    chk("post_rd_en", 32'(rd_en), 32'd1);
    while (tpos != 31) begin
      step();
      chk("post_state", 32'(state), 32'd0);
    end
    step();
    chk("post_ilas", 32'(state), 32'd1);
    step();
    chk("post_ilas_k28_0", 32'(addr), 32'h1C);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
